// File: rtl/fir_pkg.sv
// Shared types, default widths and the saturating output-slice helper for the multi-channel FIR MAC.
// The helper is used by the lanes only when FIR_MAC_SAT_EN is defined.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACC,
    FLUSH,
    DONE
  } state_t;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_COEF_W    = 16;
  localparam int unsigned DEF_ACC_W     = 33;
  localparam int unsigned DEF_OUT_SHIFT = 15;
  localparam int unsigned MAX_ACC_W     = 64;

  // acc must arrive sign-extended to MAX_ACC_W; the caller keeps the low data_w bits of the result.
  function automatic logic [MAX_ACC_W-1:0] sat_slice(input logic signed [MAX_ACC_W-1:0] acc,
                                                     input int unsigned out_shift,
                                                     input int unsigned data_w);
    logic signed [MAX_ACC_W-1:0] hi;
    logic signed [MAX_ACC_W-1:0] lim;
    hi  = acc >>> (out_shift + data_w - 1);
    lim = MAX_ACC_W'(1) << (data_w - 1);
    if (hi == '0 || hi == '1) begin
      sat_slice = acc >>> out_shift;
    end else if (acc[MAX_ACC_W-1]) begin
      sat_slice = -lim;
    end else begin
      sat_slice = lim - MAX_ACC_W'(1);
    end
  endfunction

endpackage

// File: rtl/multi_ch_fir_mac_if.sv
// Handshake, tap-address and data bus of the multi-channel FIR MAC.
// slave = the MAC itself, master = controller plus coefficient ROM / sample buffers.
interface multi_ch_fir_mac_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ADDR_W = 10
);
  logic                       start;
  logic                       busy;
  logic [ADDR_W-1:0]          tap_addr;
  logic [COEF_W-1:0]          coef_in;
  logic [NUM_CH*DATA_W-1:0]   smpl_in;
  logic [NUM_CH*DATA_W-1:0]   filt_out;
  logic                       filt_vld;

  modport master (
    output start, coef_in, smpl_in,
    input  busy, tap_addr, filt_out, filt_vld
  );

  modport slave (
    input  start, coef_in, smpl_in,
    output busy, tap_addr, filt_out, filt_vld
  );
endinterface

// File: rtl/fir_mac_lane.sv
// One signed MAC lane: clearable accumulator plus registered output slice.
// FIR_MAC_SAT_EN selects a saturating slice instead of the wrapping one.
module fir_mac_lane
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEF_W    = DEF_COEF_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic                     i_ld,
  input  logic signed [COEF_W-1:0] i_coef,
  input  logic signed [DATA_W-1:0] i_smpl,
  output logic        [DATA_W-1:0] o_out
);
  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_acc_nxt;
  logic signed [ACC_W-1:0]  r_acc;
  logic        [DATA_W-1:0] w_res;
  logic        [DATA_W-1:0] r_out;

  assign w_prod    = PROD_W'(i_coef) * PROD_W'(i_smpl);
  assign w_acc_nxt = r_acc + ACC_W'(w_prod);

  // Output is taken from the sum including the final product, so it lands in the same edge.
`ifdef FIR_MAC_SAT_EN
  assign w_res = DATA_W'(sat_slice(MAX_ACC_W'(w_acc_nxt), OUT_SHIFT, DATA_W));
`else
  assign w_res = w_acc_nxt[OUT_SHIFT +: DATA_W];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else begin
      if (i_clr) begin
        r_acc <= '0;
      end else if (i_en) begin
        r_acc <= w_acc_nxt;
      end
      if (i_ld) begin
        r_out <= w_res;
      end
    end
  end

  assign o_out = r_out;
endmodule

// File: rtl/multi_ch_fir_mac.sv
// Multi-channel FIR MAC: start/busy/valid controller and tap address counter driving NUM_CH lanes.
// Optional macro FIR_MAC_SAT_EN makes every lane saturate its output.
module multi_ch_fir_mac
  import fir_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned NUM_TAPS  = 1021,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned COEF_W    = DEF_COEF_W,
  parameter int unsigned ACC_W     = DEF_ACC_W,
  parameter int unsigned OUT_SHIFT = DEF_OUT_SHIFT,
  parameter int unsigned ADDR_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  multi_ch_fir_mac_if.slave  bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

  state_t            r_state;
  logic              r_busy;
  logic              r_vld;
  logic [ADDR_W-1:0] r_addr;
  logic              w_clr;
  logic              w_en;
  logic              w_ld;

  // Data for the address issued last cycle is valid throughout ACC and FLUSH.
  assign w_clr = (r_state == IDLE) && bus.start;
  assign w_en  = (r_state == ACC) || (r_state == FLUSH);
  assign w_ld  = (r_state == FLUSH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_vld   <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          r_addr <= '0;
          if (bus.start) begin
            r_state <= ISSUE;
            r_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (NUM_TAPS == 1) begin
            r_state <= FLUSH;
          end else begin
            r_state <= ACC;
            r_addr  <= r_addr + ADDR_W'(1);
          end
        end
        ACC: begin
          if (r_addr == LAST_ADDR) begin
            r_state <= FLUSH;
          end else begin
            r_addr <= r_addr + ADDR_W'(1);
          end
        end
        FLUSH: begin
          r_state <= DONE;
          r_vld   <= 1'b1;
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_addr  <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_addr  <= '0;
        end
      endcase
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lane
    fir_mac_lane #(
      .DATA_W   (DATA_W),
      .COEF_W   (COEF_W),
      .ACC_W    (ACC_W),
      .OUT_SHIFT(OUT_SHIFT)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .i_clr (w_clr),
      .i_en  (w_en),
      .i_ld  (w_ld),
      .i_coef(bus.coef_in),
      .i_smpl(bus.smpl_in[ch*DATA_W +: DATA_W]),
      .o_out (bus.filt_out[ch*DATA_W +: DATA_W])
    );
  end

  assign bus.busy     = r_busy;
  assign bus.filt_vld = r_vld;
  assign bus.tap_addr = r_addr;
endmodule

// File: tb/tb_multi_ch_fir_mac.sv
// Self-checking bench for multi_ch_fir_mac: 8-, 4- and 1-tap instances sharing one ROM/sample model.
module tb_multi_ch_fir_mac;
  localparam int SH = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] st = '0;
  logic signed [15:0] coef_mem [8];
  logic signed [15:0] smpl_mem [2][8];
  int n_cmp = 0;
  int n_err = 0;
  logic addr1_moved = 1'b0;

  multi_ch_fir_mac_if #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .ADDR_W(3)) if8 ();
  multi_ch_fir_mac_if #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .ADDR_W(2)) if4 ();
  multi_ch_fir_mac_if #(.NUM_CH(2), .DATA_W(16), .COEF_W(16), .ADDR_W(1)) if1 ();

  multi_ch_fir_mac #(.NUM_CH(2), .NUM_TAPS(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  multi_ch_fir_mac #(.NUM_CH(2), .NUM_TAPS(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  multi_ch_fir_mac #(.NUM_CH(2), .NUM_TAPS(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if8.start = st[0];
  assign if4.start = st[1];
  assign if1.start = st[2];

  // ROM and sample buffer: data returns one cycle after the address.
  always @(posedge clk) begin
    if8.coef_in <= coef_mem[if8.tap_addr];
    if8.smpl_in <= {smpl_mem[1][if8.tap_addr], smpl_mem[0][if8.tap_addr]};
    if4.coef_in <= coef_mem[if4.tap_addr];
    if4.smpl_in <= {smpl_mem[1][if4.tap_addr], smpl_mem[0][if4.tap_addr]};
    if1.coef_in <= coef_mem[if1.tap_addr];
    if1.smpl_in <= {smpl_mem[1][if1.tap_addr], smpl_mem[0][if1.tap_addr]};
  end

  logic [2:0]  vld;
  logic [2:0]  busy;
  logic [31:0] fout [3];
  logic [2:0]  addr [3];
  assign vld     = {if1.filt_vld, if4.filt_vld, if8.filt_vld};
  assign busy    = {if1.busy, if4.busy, if8.busy};
  assign fout[0] = if8.filt_out;
  assign fout[1] = if4.filt_out;
  assign fout[2] = if1.filt_out;
  assign addr[0] = if8.tap_addr;
  assign addr[1] = {1'b0, if4.tap_addr};
  assign addr[2] = {2'b0, if1.tap_addr};

  always @(negedge clk) if (!rst && if1.tap_addr != 1'b0) addr1_moved <= 1'b1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: exact dot product, wrapped to 33-bit two's complement, then scaled by 2^-15.
  function automatic logic [15:0] model(input int n, input int ch);
    longint acc = 0;
    longint q;
    for (int t = 0; t < n; t++) acc += longint'(coef_mem[t]) * longint'(smpl_mem[ch][t]);
    acc = (acc <<< 31) >>> 31;
    q = acc >>> SH;
`ifdef FIR_MAC_SAT_EN
    if (q > 32767) return 16'h7FFF;
    if (q < -32768) return 16'h8000;
`endif
    return q[15:0];
  endfunction

  task automatic fill_random();
    for (int t = 0; t < 8; t++) begin
      coef_mem[t]    = 16'($urandom);
      smpl_mem[0][t] = 16'($urandom);
      smpl_mem[1][t] = 16'($urandom);
    end
  endtask

  task automatic fill_const(input logic [15:0] c, input logic [15:0] s0, input logic [15:0] s1);
    for (int t = 0; t < 8; t++) begin
      coef_mem[t]    = c;
      smpl_mem[0][t] = s0;
      smpl_mem[1][t] = s1;
    end
  endtask

  // Entered and left at a negedge with the DUT idle.
  task automatic run_op(input int i, input int n);
    int cyc;
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
    cyc = 1;
    chk("busy_cycle1", 32'(busy[i]), 32'd1);
    chk("addr_cycle1", 32'(addr[i]), 32'd0);
    while (vld[i] !== 1'b1 && cyc < n + 10) begin
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(n + 2));
    chk("addr_done", 32'(addr[i]), 32'(n - 1));
    for (int ch = 0; ch < 2; ch++) chk("filt_out", 32'(fout[i][ch*16 +: 16]), 32'(model(n, ch)));
    @(negedge clk);
    chk("vld_one_cycle", 32'(vld[i]), 32'd0);
    chk("busy_released", 32'(busy[i]), 32'd0);
  endtask

  initial begin
    int vcnt;
    int vcyc;
    fill_const(16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy[i]), 32'd0);
      chk("rst_vld", 32'(vld[i]), 32'd0);
      chk("rst_out", fout[i], 32'd0);
      chk("rst_addr", 32'(addr[i]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Impulse at tap 3 on the 8-tap instance.
    for (int t = 0; t < 8; t++) begin
      coef_mem[t]    = 16'(t + 1);
      smpl_mem[0][t] = (t == 3) ? 16'sh7FFF : 16'sh0;
      smpl_mem[1][t] = (t == 3) ? 16'sh7FFF : 16'sh0;
    end
    run_op(0, 8);
    chk("impulse_ch0", 32'(fout[0][15:0]), 32'h0003);
    chk("impulse_ch1", 32'(fout[0][31:16]), 32'h0003);

    // Opposite-sign lanes on the 4-tap instance.
    fill_const(16'h0800, 16'h4000, 16'hC000);
    run_op(1, 4);
    chk("lane_ch0", 32'(fout[1][15:0]), 32'h1000);
    chk("lane_ch1", 32'(fout[1][31:16]), 32'hF000);

    // Full-scale input overflows the output slice.
    fill_const(16'h7FFF, 16'h7FFF, 16'h7FFF);
    run_op(1, 4);
`ifdef FIR_MAC_SAT_EN
    chk("sat_ch0", 32'(fout[1][15:0]), 32'h7FFF);
`else
    chk("wrap_ch0", 32'(fout[1][15:0]), 32'hFFF8);
`endif

    // Single tap.
    fill_const(16'h4000, 16'h2000, 16'h2000);
    run_op(2, 1);
    chk("one_tap_ch0", 32'(fout[2][15:0]), 32'h1000);

    // Start pulses at cycles 0, 3 and 10 on the 8-tap instance: only the first counts.
    fill_random();
    vcnt = 0;
    vcyc = -1;
    for (int c = 0; c <= 24; c++) begin
      if (c > 0) @(negedge clk);
      if (vld[0] === 1'b1) begin
        vcnt++;
        vcyc = c;
      end
      if (c == 1) chk("hs_busy_c1", 32'(busy[0]), 32'd1);
      if (c == 10) begin
        chk("hs_out_ch0", 32'(fout[0][15:0]), 32'(model(8, 0)));
        chk("hs_out_ch1", 32'(fout[0][31:16]), 32'(model(8, 1)));
      end
      if (c == 11) chk("hs_busy_c11", 32'(busy[0]), 32'd0);
      if (c == 13) chk("hs_no_restart", 32'(busy[0]), 32'd0);
      st[0] = (c == 0 || c == 3 || c == 10);
    end
    st[0] = 1'b0;
    chk("hs_vld_count", 32'(vcnt), 32'd1);
    chk("hs_vld_cycle", 32'(vcyc), 32'd10);

    // Reset at cycle 5 of an 8-tap run.
    fill_random();
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_out", fout[0], 32'd0);
    chk("abort_addr", 32'(addr[0]), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (vld[0] === 1'b1) vcnt++;
      @(negedge clk);
    end
    chk("abort_no_vld", 32'(vcnt), 32'd0);

    // Start coincident with reset is lost.
    st[0] = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    rst   = 1'b0;
    chk("rst_start_busy", 32'(busy[0]), 32'd0);
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (vld[0] === 1'b1 || busy[0] === 1'b1) vcnt++;
      @(negedge clk);
    end
    chk("rst_start_idle", 32'(vcnt), 32'd0);

    // Fresh run after the abort: no residue.
    fill_random();
    run_op(0, 8);

    // Random data on every instance, including accumulator wrap.
    for (int k = 0; k < 9; k++) begin
      fill_random();
      case (k % 3)
        0: run_op(0, 8);
        1: run_op(1, 4);
        default: run_op(2, 1);
      endcase
    end

    chk("one_tap_addr_fixed", 32'(addr1_moved), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
